// File: rtl/axi4_wr_buffer.sv
`default_nettype none
// ============================================================================
// Module   : axi4_wr_buffer (with helper axi4_wr_buffer_fifo)
// Purpose  : AXI4 AW/W write-path buffer. AW and W each pass through a
//            first-word-fall-through FIFO. A W beat is released downstream
//            only after its burst's AW has been issued. Beats are counted
//            against awlen, and any WLAST mismatch raises wlast_err.
// Ports    : aclk/areset        - clock, asynchronous active-high reset
//            s_aw*/s_w*         - upstream AW/W channels (manager side)
//            m_aw*/m_w*         - downstream AW/W channels (subordinate side)
//            aw_count/w_count   - AW/W FIFO occupancy
//            wlast_err          - one-cycle pulse after a WLAST mismatch
// Options  : `define AXI4_WR_BUF_WLAST_FIX_EN regenerates m_wlast from the
//            beat count instead of forwarding the stored s_wlast.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// axi4_wr_buffer_fifo: register-array FWFT FIFO. Pointers carry one extra
// wrap bit so that full and empty can be told apart without a counter.
// Pushes and pops must be qualified by the caller, never into full or out of
// empty.
// ----------------------------------------------------------------------------
module axi4_wr_buffer_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W:0]   wr_ptr_q;
   logic [PTR_W:0]   rd_ptr_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage is not reset: stale entries are unreachable once pointers clear.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];
   assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
endmodule

module axi4_wr_buffer #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int USER_WIDTH = 1,
   parameter int AW_DEPTH   = 4,
   parameter int W_DEPTH    = 16
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [ID_WIDTH-1:0]       s_awid,
   input  logic [ADDR_WIDTH-1:0]     s_awaddr,
   input  logic [7:0]                s_awlen,
   input  logic [2:0]                s_awsize,
   input  logic [1:0]                s_awburst,
   input  logic [USER_WIDTH-1:0]     s_awuser,
   input  logic                      s_awvalid,
   output logic                      s_awready,
   input  logic [DATA_WIDTH-1:0]     s_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
   input  logic                      s_wlast,
   input  logic [USER_WIDTH-1:0]     s_wuser,
   input  logic                      s_wvalid,
   output logic                      s_wready,
   output logic [ID_WIDTH-1:0]       m_awid,
   output logic [ADDR_WIDTH-1:0]     m_awaddr,
   output logic [7:0]                m_awlen,
   output logic [2:0]                m_awsize,
   output logic [1:0]                m_awburst,
   output logic [USER_WIDTH-1:0]     m_awuser,
   output logic                      m_awvalid,
   input  logic                      m_awready,
   output logic [DATA_WIDTH-1:0]     m_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_wstrb,
   output logic                      m_wlast,
   output logic [USER_WIDTH-1:0]     m_wuser,
   output logic                      m_wvalid,
   input  logic                      m_wready,
   output logic [$clog2(AW_DEPTH):0] aw_count,
   output logic [$clog2(W_DEPTH):0]  w_count,
   output logic                      wlast_err
);
   localparam int AWP_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + USER_WIDTH;
   localparam int WP_W  = DATA_WIDTH + DATA_WIDTH/8 + 1 + USER_WIDTH;

   logic [AWP_W-1:0]          aw_head;
   logic [WP_W-1:0]           w_head;
   logic                      aw_full;
   logic                      w_full;
   logic                      lenq_full;
   logic [$clog2(AW_DEPTH):0] lenq_count;
   logic [7:0]                head_len;
   logic                      stored_wlast;
   logic                      aw_push;
   logic                      w_push;
   logic                      aw_hs;
   logic                      w_hs;
   logic                      at_end;
   logic                      burst_end;
   logic [7:0]                beat_cnt_q;
   logic [7:0]                beat_cnt_d;
   logic                      wlast_err_q;
   logic                      wlast_err_d;

   // Ingress readiness looks at full only; a same-cycle pop does not help.
   assign s_awready = !areset && !aw_full;
   assign s_wready  = !areset && !w_full;
   assign aw_push   = s_awvalid && s_awready;
   assign w_push    = s_wvalid && s_wready;

   axi4_wr_buffer_fifo #(.WIDTH(AWP_W), .DEPTH(AW_DEPTH)) u_aw_fifo (
      .clk_i   (aclk),
      .rst_i   (areset),
      .push_i  (aw_push),
      .data_i  ({s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awuser}),
      .pop_i   (aw_hs),
      .data_o  (aw_head),
      .full_o  (aw_full),
      .count_o (aw_count)
   );

   axi4_wr_buffer_fifo #(.WIDTH(WP_W), .DEPTH(W_DEPTH)) u_w_fifo (
      .clk_i   (aclk),
      .rst_i   (areset),
      .push_i  (w_push),
      .data_i  ({s_wdata, s_wstrb, s_wlast, s_wuser}),
      .pop_i   (w_hs),
      .data_o  (w_head),
      .full_o  (w_full),
      .count_o (w_count)
   );

   // Lengths of bursts whose AW has gone downstream but whose W beats have
   // not all been forwarded yet. Its head governs the current W burst.
   axi4_wr_buffer_fifo #(.WIDTH(8), .DEPTH(AW_DEPTH)) u_len_q (
      .clk_i   (aclk),
      .rst_i   (areset),
      .push_i  (aw_hs),
      .data_i  (m_awlen),
      .pop_i   (burst_end),
      .data_o  (head_len),
      .full_o  (lenq_full),
      .count_o (lenq_count)
   );

   assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awuser} = aw_head;
   assign {m_wdata, m_wstrb, stored_wlast, m_wuser} = w_head;

   // AW is held back while the length queue cannot record its awlen.
   assign m_awvalid = (aw_count != '0) && !lenq_full;
   assign aw_hs     = m_awvalid && m_awready;

   // A W beat needs an issued-but-unfinished AW to belong to.
   assign m_wvalid  = (w_count != '0) && (lenq_count != '0);
   assign w_hs      = m_wvalid && m_wready;

   assign at_end    = (beat_cnt_q == head_len);
   // Either marker closes the burst: early wlast truncates it, a missing
   // wlast is overridden once awlen+1 beats have gone through.
   assign burst_end = w_hs && (at_end || stored_wlast);

`ifdef AXI4_WR_BUF_WLAST_FIX_EN
   assign m_wlast = at_end;
`else
   assign m_wlast = stored_wlast;
`endif

   always_comb begin
      beat_cnt_d  = beat_cnt_q;
      wlast_err_d = 1'b0;
      if (w_hs) begin
         beat_cnt_d  = burst_end ? 8'd0 : beat_cnt_q + 8'd1;
         wlast_err_d = (stored_wlast != at_end);
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         beat_cnt_q  <= 8'd0;
         wlast_err_q <= 1'b0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         wlast_err_q <= wlast_err_d;
      end
   end

   assign wlast_err = wlast_err_q;
endmodule
`default_nettype wire

// File: tb/tb_axi4_wr_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_wr_buffer
// Purpose  : Self-checking bench for axi4_wr_buffer. Randomised sources and
//            sinks drive the block; a queue-based model of the ordering and
//            burst rules predicts every downstream transfer, the readiness,
//            occupancy and the wlast_err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_wr_buffer;
   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int ID_WIDTH   = 4;
   localparam int USER_WIDTH = 1;
   localparam int AW_DEPTH   = 4;
   localparam int W_DEPTH    = 16;

   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [ADDR_WIDTH-1:0] addr;
      logic [7:0]            len;
      logic [2:0]            size;
      logic [1:0]            burst;
      logic [USER_WIDTH-1:0] user;
   } aw_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]   data;
      logic [DATA_WIDTH/8-1:0] strb;
      logic                    last;
      logic [USER_WIDTH-1:0]   user;
   } wbeat_t;

   logic aclk = 1'b0;
   logic areset = 1'b1;
   logic [ID_WIDTH-1:0]       s_awid = '0;
   logic [ADDR_WIDTH-1:0]     s_awaddr = '0;
   logic [7:0]                s_awlen = '0;
   logic [2:0]                s_awsize = '0;
   logic [1:0]                s_awburst = '0;
   logic [USER_WIDTH-1:0]     s_awuser = '0;
   logic                      s_awvalid = 1'b0;
   logic                      s_awready;
   logic [DATA_WIDTH-1:0]     s_wdata = '0;
   logic [DATA_WIDTH/8-1:0]   s_wstrb = '0;
   logic                      s_wlast = 1'b0;
   logic [USER_WIDTH-1:0]     s_wuser = '0;
   logic                      s_wvalid = 1'b0;
   logic                      s_wready;
   logic [ID_WIDTH-1:0]       m_awid;
   logic [ADDR_WIDTH-1:0]     m_awaddr;
   logic [7:0]                m_awlen;
   logic [2:0]                m_awsize;
   logic [1:0]                m_awburst;
   logic [USER_WIDTH-1:0]     m_awuser;
   logic                      m_awvalid;
   logic                      m_awready = 1'b0;
   logic [DATA_WIDTH-1:0]     m_wdata;
   logic [DATA_WIDTH/8-1:0]   m_wstrb;
   logic                      m_wlast;
   logic [USER_WIDTH-1:0]     m_wuser;
   logic                      m_wvalid;
   logic                      m_wready = 1'b0;
   logic [$clog2(AW_DEPTH):0] aw_count;
   logic [$clog2(W_DEPTH):0]  w_count;
   logic                      wlast_err;

   always #5 aclk = ~aclk;

   axi4_wr_buffer #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH),
      .USER_WIDTH(USER_WIDTH), .AW_DEPTH(AW_DEPTH), .W_DEPTH(W_DEPTH)
   ) dut (
      .aclk(aclk), .areset(areset),
      .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
      .s_awburst(s_awburst), .s_awuser(s_awuser), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wuser(s_wuser),
      .s_wvalid(s_wvalid), .s_wready(s_wready),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awburst(m_awburst), .m_awuser(m_awuser), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wuser(m_wuser),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .aw_count(aw_count), .w_count(w_count), .wlast_err(wlast_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // Sources (not yet offered/accepted) and model of buffered content.
   aw_t    src_aw[$];
   wbeat_t src_w[$];
   aw_t    mdl_aw[$];
   wbeat_t mdl_w[$];
   logic [7:0] mdl_len[$];     // lengths of bursts issued downstream, not finished
   int  beats_done = 0;        // beats already forwarded in the current burst
   bit  err_pend = 1'b0;
   int  w_out_total = 0;
   int  aw_vld_pct = 100, w_vld_pct = 100, aw_rdy_pct = 100, w_rdy_pct = 100;

   task automatic model_reset();
      src_aw.delete(); src_w.delete();
      mdl_aw.delete(); mdl_w.delete(); mdl_len.delete();
      beats_done = 0;
      err_pend   = 1'b0;
      s_awvalid  = 1'b0;
      s_wvalid   = 1'b0;
   endtask

   // last_at: beat index carrying wlast; negative means wlast never set.
   task automatic add_burst(input int len, input int last_at, input logic [31:0] addr);
      aw_t a;
      wbeat_t b;
      int n;
      a.id    = 4'($urandom);
      a.addr  = addr;
      a.len   = 8'(len);
      a.size  = 3'd2;
      a.burst = 2'b01;
      a.user  = 1'($urandom);
      src_aw.push_back(a);
      n = (last_at >= 0 && last_at < len) ? last_at + 1 : len + 1;
      for (int i = 0; i < n; i++) begin
         b.data = $urandom;
         b.strb = 4'($urandom);
         b.last = (i == last_at);
         b.user = 1'($urandom);
         src_w.push_back(b);
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic tick();
      bit aw_in, w_in, aw_out, w_out, at_end, exp_last;
      aw_t a;
      wbeat_t b;
      if (!s_awvalid && src_aw.size() > 0 && $urandom_range(99) < aw_vld_pct) begin
         s_awvalid = 1'b1;
         {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awuser} = src_aw[0];
      end
      if (!s_wvalid && src_w.size() > 0 && $urandom_range(99) < w_vld_pct) begin
         s_wvalid = 1'b1;
         {s_wdata, s_wstrb, s_wlast, s_wuser} = src_w[0];
      end
      m_awready = ($urandom_range(99) < aw_rdy_pct);
      m_wready  = ($urandom_range(99) < w_rdy_pct);
      #1;
      check("s_awready", 64'(s_awready), 64'(!areset && mdl_aw.size() < AW_DEPTH));
      check("s_wready",  64'(s_wready),  64'(!areset && mdl_w.size() < W_DEPTH));
      check("aw_count",  64'(aw_count),  64'(mdl_aw.size()));
      check("w_count",   64'(w_count),   64'(mdl_w.size()));
      check("m_awvalid", 64'(m_awvalid), 64'(!areset && mdl_aw.size() > 0 && mdl_len.size() < AW_DEPTH));
      check("m_wvalid",  64'(m_wvalid),  64'(!areset && mdl_w.size() > 0 && mdl_len.size() > 0));
      check("wlast_err", 64'(wlast_err), 64'(err_pend));
      if (m_awvalid && mdl_aw.size() > 0)
         check("m_aw_payload", 64'({m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awuser}),
               64'(mdl_aw[0]));
      if (m_wvalid && mdl_w.size() > 0 && mdl_len.size() > 0) begin
         at_end = (beats_done == int'(mdl_len[0]));
`ifdef AXI4_WR_BUF_WLAST_FIX_EN
         exp_last = at_end;
`else
         exp_last = mdl_w[0].last;
`endif
         check("m_w_payload", 64'({m_wdata, m_wstrb, m_wuser}),
               64'({mdl_w[0].data, mdl_w[0].strb, mdl_w[0].user}));
         check("m_wlast", 64'(m_wlast), 64'(exp_last));
      end
      aw_in  = s_awvalid && s_awready;
      w_in   = s_wvalid && s_wready;
      aw_out = m_awvalid && m_awready;
      w_out  = m_wvalid && m_wready;
      @(posedge aclk);
      err_pend = 1'b0;
      if (w_out && mdl_w.size() > 0 && mdl_len.size() > 0) begin
         b = mdl_w.pop_front();
         at_end = (beats_done == int'(mdl_len[0]));
         err_pend = (b.last != at_end);
         if (at_end || b.last) begin
            void'(mdl_len.pop_front());
            beats_done = 0;
         end else begin
            beats_done++;
         end
         w_out_total++;
      end
      if (aw_out && mdl_aw.size() > 0) begin
         a = mdl_aw.pop_front();
         mdl_len.push_back(a.len);
      end
      if (aw_in && src_aw.size() > 0) mdl_aw.push_back(src_aw.pop_front());
      if (w_in && src_w.size() > 0)   mdl_w.push_back(src_w.pop_front());
      @(negedge aclk);
      if (aw_in) s_awvalid = 1'b0;
      if (w_in)  s_wvalid  = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((src_aw.size() + src_w.size() + mdl_aw.size() + mdl_w.size()) > 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain_left", 64'(src_aw.size() + src_w.size() + mdl_aw.size() + mdl_w.size()), 64'd0);
      repeat (2) tick();   // let any trailing wlast_err pulse be observed
   endtask

   initial begin
      int start, n, len, r, la;
      @(negedge aclk);
      repeat (2) tick();                    // reset state, readies low
      areset = 1'b0;
      tick();

      // Single clean burst.
      add_burst(3, 3, 32'h0000_1000);
      drain(100);

      // W beats arrive long before their AW.
      aw_vld_pct = 0;
      add_burst(3, 3, 32'h0000_2000);
      repeat (5) tick();
      check("w_first_count", 64'(w_count), 64'd4);
      check("w_first_gated", 64'(m_wvalid), 64'd0);
      aw_vld_pct = 100;
      drain(100);

      // AW FIFO full boundary with a stalled downstream AW.
      aw_rdy_pct = 0;
      for (int i = 0; i < 5; i++) add_burst(0, 0, 32'h3000 + 32'(i * 16));
      repeat (8) tick();
      check("aw_full_count", 64'(aw_count), 64'(AW_DEPTH));
      check("aw_full_ready", 64'(s_awready), 64'd0);
      aw_rdy_pct = 100;
      drain(200);

      // Early wlast, then missing wlast, each followed by a clean burst.
      add_burst(3, 1, 32'h4000);
      add_burst(3, 3, 32'h4100);
      add_burst(1, -1, 32'h4200);
      add_burst(2, 2, 32'h4300);
      drain(200);

      // Random backpressure over 16 beats.
      aw_rdy_pct = 70; w_rdy_pct = 50; aw_vld_pct = 80; w_vld_pct = 80;
      for (int i = 0; i < 4; i++) add_burst(3, 3, 32'h5000 + 32'(i * 64));
      drain(1000);

      // Randomised bursts, including early and missing wlast.
      for (int k = 0; k < 40; k++) begin
         len = int'($urandom_range(15));
         r   = int'($urandom_range(9));
         if (r == 0)      la = (len > 0) ? int'($urandom_range(len - 1)) : 0;
         else if (r == 1) la = -1;
         else             la = len;
         add_burst(len, la, $urandom);
      end
      aw_rdy_pct = 60; w_rdy_pct = 60; aw_vld_pct = 70; w_vld_pct = 90;
      drain(6000);

      // Asynchronous reset in the middle of an awlen=7 burst.
      aw_rdy_pct = 100; w_rdy_pct = 100; aw_vld_pct = 100; w_vld_pct = 100;
      add_burst(7, 7, 32'h6000);
      start = w_out_total;
      n = 0;
      while (w_out_total - start < 2 && n < 50) begin
         tick();
         n++;
      end
      check("rst_mid_beats", 64'(w_out_total - start), 64'd2);
      #2 areset = 1'b1;
      #1;
      check("rst_mid_wvalid",  64'(m_wvalid),  64'd0);
      check("rst_mid_awvalid", 64'(m_awvalid), 64'd0);
      check("rst_mid_awcount", 64'(aw_count),  64'd0);
      check("rst_mid_wcount",  64'(w_count),   64'd0);
      check("rst_mid_ready",   64'(s_wready),  64'd0);
      model_reset();
      @(negedge aclk);
      repeat (2) tick();
      areset = 1'b0;
      add_burst(2, 2, 32'h7000);
      drain(100);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
